// File: rtl/maze_run_ctrl_if.sv
// Bundle of the carver, player-move, VGA read and status signals around maze_run_ctrl.
interface maze_run_ctrl_if;
  logic         new_round;
  logic         carver_start;
  logic         carver_finish;
  logic [255:0] carver_maze;
  logic         move_valid;
  logic [1:0]   move_dir;
  logic         move_ack;
  logic         move_nak;
  logic [3:0]   player_x;
  logic [3:0]   player_y;
  logic [7:0]   rd_addr;
  logic         rd_data;
  logic [2:0]   state;
  logic         won;
  logic         error;

  // master is the surrounding system (carver, player input, renderer); slave is the controller
  modport master (
    output new_round, carver_finish, carver_maze, move_valid, move_dir, rd_addr,
    input  carver_start, move_ack, move_nak, player_x, player_y, rd_data, state, won, error
  );

  modport slave (
    input  new_round, carver_finish, carver_maze, move_valid, move_dir, rd_addr,
    output carver_start, move_ack, move_nak, player_x, player_y, rd_data, state, won, error
  );
endinterface

// File: rtl/maze_run_ctrl.sv
// Round sequencer: launch and qualify the maze carver, snapshot its map, serve it to VGA,
// then track the player until the goal cell is reached.
module maze_run_ctrl #(
  parameter int unsigned START_CYCLES   = 4,
  parameter int unsigned MIN_GEN_CYCLES = 64,
  parameter int unsigned MAX_GEN_CYCLES = 65535,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned GOAL_X         = 15,
  parameter int unsigned GOAL_Y         = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  maze_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_GEN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_PLAY    = 3'd4,
    S_WIN     = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  localparam logic [15:0]  START_LAST = 16'(START_CYCLES - 1);
  localparam logic [15:0]  MIN_C      = 16'(MIN_GEN_CYCLES);
  localparam logic [15:0]  MAX_C      = 16'(MAX_GEN_CYCLES);
  localparam logic [7:0]   RETRY_MAX  = 8'(MAX_RETRIES);
  localparam logic [3:0]   GX         = 4'(GOAL_X);
  localparam logic [3:0]   GY         = 4'(GOAL_Y);
  localparam logic [255:0] FORCED     = (256'd1) | (256'd1 << (GOAL_Y * 16 + GOAL_X));

  state_t       cur, nxt;
  logic [15:0]  cnt;
  logic [7:0]   retry;
  logic [255:0] snap;
  logic [3:0]   px, py;
  logic         ack, nak, rd_q;

  logic         cnt_clr, retry_clr, retry_inc, snap_clr, snap_load, move_go;
  logic [3:0]   tx, ty;
  logic         in_range, move_ok;

  // Target cell of a requested move; edges are rejected rather than wrapped.
  always_comb begin
    tx       = px;
    ty       = py;
    in_range = 1'b1;
    case (bus.move_dir)
      2'b00: begin in_range = (py != 4'd0);  ty = py - 4'd1; end
      2'b01: begin in_range = (px != 4'd0);  tx = px - 4'd1; end
      2'b10: begin in_range = (py != 4'd15); ty = py + 4'd1; end
      default: begin in_range = (px != 4'd15); tx = px + 4'd1; end
    endcase
    move_ok = in_range && snap[{ty, tx}];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    cnt_clr   = 1'b0;
    retry_clr = 1'b0;
    retry_inc = 1'b0;
    snap_clr  = 1'b0;
    snap_load = 1'b0;
    move_go   = 1'b0;
    case (cur)
      S_IDLE: begin
        if (bus.new_round) begin
          nxt       = S_LAUNCH;
          cnt_clr   = 1'b1;
          retry_clr = 1'b1;
          snap_clr  = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (cnt == START_LAST) begin
          nxt     = S_GEN;
          cnt_clr = 1'b1;
        end
      end
      S_GEN: begin
        // A qualified finish takes priority over a timeout on the same cycle.
        if ((cnt >= MIN_C) && bus.carver_finish) begin
          nxt = S_CAPTURE;
        end else if (cnt >= MAX_C) begin
          cnt_clr = 1'b1;
          if (retry < RETRY_MAX) begin
            retry_inc = 1'b1;
            nxt       = S_LAUNCH;
          end else begin
            nxt = S_ERROR;
          end
        end
      end
      S_CAPTURE: begin
        snap_load = 1'b1;
        nxt       = S_PLAY;
      end
      S_PLAY: begin
        if (bus.move_valid) begin
          move_go = 1'b1;
          if (move_ok && (tx == GX) && (ty == GY)) nxt = S_WIN;
        end
      end
      S_WIN: begin
        if (bus.new_round) begin
          nxt       = S_LAUNCH;
          cnt_clr   = 1'b1;
          retry_clr = 1'b1;
          snap_clr  = 1'b1;
        end
      end
      S_ERROR: begin
        if (bus.new_round) begin
          nxt       = S_LAUNCH;
          cnt_clr   = 1'b1;
          retry_clr = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // One counter serves both the launch pulse width and the generation window.
  always_ff @(posedge clk) begin
    if (!rst_n)                            cnt <= 16'd0;
    else if (cnt_clr)                      cnt <= 16'd0;
    else if (cur == S_LAUNCH || cur == S_GEN) cnt <= cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         retry <= 8'd0;
    else if (retry_clr) retry <= 8'd0;
    else if (retry_inc) retry <= retry + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         snap <= '0;
    else if (snap_clr)  snap <= '0;
    else if (snap_load) snap <= bus.carver_maze | FORCED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px  <= 4'd0;
      py  <= 4'd0;
      ack <= 1'b0;
      nak <= 1'b0;
    end else begin
      ack <= move_go && move_ok;
      nak <= move_go && !move_ok;
      if (snap_load) begin
        px <= 4'd0;
        py <= 4'd0;
      end else if (move_go && move_ok) begin
        px <= tx;
        py <= ty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_q <= 1'b0;
    else        rd_q <= snap[bus.rd_addr];
  end

  assign bus.carver_start = (cur == S_LAUNCH);
  assign bus.move_ack     = ack;
  assign bus.move_nak     = nak;
  assign bus.player_x     = px;
  assign bus.player_y     = py;
  assign bus.rd_data      = rd_q;
  assign bus.state        = cur;
  assign bus.won          = (cur == S_WIN);
  assign bus.error        = (cur == S_ERROR);

endmodule
